// File: rtl/tick_pkg.sv
// tick_pkg: shared widths, reset defaults and encodings for the tick controller.
package tick_pkg;
  localparam int CNT_W = 20;
  localparam int NTK_W = 8;
  localparam logic [CNT_W-1:0] DEFAULT_PERIOD = CNT_W'(1000000);
  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: free-running prescale counter with terminal compare and registered wrap pulse.
module tick_prescaler
  import tick_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] period,
  output logic             term,
  output logic             wrap
);
  logic [CNT_W-1:0] q;
  // period is always at least 2, so period-1 never underflows
  assign term = q == period - 1'b1;
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q    <= '0;
      wrap <= 1'b0;
    end else if (en) begin
      q    <= term ? '0 : q + 1'b1;
      wrap <= term;
    end else begin
      wrap <= 1'b0;
    end
  end
endmodule

// File: rtl/tick_ctrl.sv
// tick_ctrl: config registers, run FSM, tick counting and done generation around the prescaler.
module tick_ctrl
  import tick_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [NTK_W-1:0] cfg_ticks,
  input  logic             cfg_mode,
  input  logic             start,
  input  logic             stop,
  output logic             tick,
  output logic             done,
  output logic             busy,
  output logic [NTK_W-1:0] tick_cnt
);
  state_t           state, state_nxt;
  logic [CNT_W-1:0] period_r, p_eff;
  logic [NTK_W-1:0] ticks_r, n_eff;
  logic             mode_r, start_go, stop_go, term, fire, last;
  assign p_eff    = period_r < CNT_W'(2) ? CNT_W'(2) : period_r;
  assign n_eff    = ticks_r == '0 ? NTK_W'(1) : ticks_r;
  assign start_go = state == IDLE && start && !stop;
  assign stop_go  = state == RUN && stop;
  // stop wins over a coincident terminal count
  assign fire     = state == RUN && !stop && term;
  assign last     = fire && ({1'b0, tick_cnt} + 1'b1 == {1'b0, n_eff});
  tick_prescaler u_pre (
    .clk   (clk),
    .rst   (rst),
    .en    (state == RUN),
    .clr   (start_go || stop_go),
    .period(p_eff),
    .term  (term),
    .wrap  (tick)
  );
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    if (state == IDLE) state_nxt = start_go ? RUN : IDLE;
    else state_nxt = (stop || (last && mode_r == MODE_ONESHOT)) ? IDLE : RUN;
  end
  always_comb begin
    busy = state == RUN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      period_r <= DEFAULT_PERIOD;
      ticks_r  <= NTK_W'(1);
      mode_r   <= MODE_ONESHOT;
    end else if (state == IDLE && cfg_we) begin
      period_r <= cfg_period;
      ticks_r  <= cfg_ticks;
      mode_r   <= cfg_mode;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      done     <= 1'b0;
      tick_cnt <= '0;
    end else begin
      done <= last;
      if (start_go) tick_cnt <= '0;
      else if (fire) tick_cnt <= (last && mode_r == MODE_PERIODIC) ? '0 : tick_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_tick_ctrl.sv
// tb_tick_ctrl: table vectors, directed corner sequences and randomized run against a reference model.
module tb_tick_ctrl;
  import tick_pkg::*;
  logic             clk = 0, rst = 0, cfg_we = 0, cfg_mode = 0, start = 0, stop = 0;
  logic [CNT_W-1:0] cfg_period = '0;
  logic [NTK_W-1:0] cfg_ticks = '0;
  logic             tick, done, busy;
  logic [NTK_W-1:0] tick_cnt;
  int total = 0, bad = 0;

  tick_ctrl dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_period(cfg_period), .cfg_ticks(cfg_ticks),
    .cfg_mode(cfg_mode), .start(start), .stop(stop), .tick(tick), .done(done), .busy(busy),
    .tick_cnt(tick_cnt)
  );

  always #5 clk = ~clk;

  // reference model: time since start, ticks on multiples of the effective period
  bit m_run, m_tick, m_done, m_mode;
  int m_cyc, m_cnt, m_p, m_n;

  task automatic model(input bit r, we, input int p, n, input bit m, s, sp);
    int pe, ne;
    if (r) begin
      m_run = 0; m_cyc = 0; m_cnt = 0; m_tick = 0; m_done = 0;
      m_p = 1000000; m_n = 1; m_mode = 0;
    end else if (!m_run) begin
      m_tick = 0; m_done = 0;
      if (we) begin m_p = p; m_n = n; m_mode = m; end
      if (s && !sp) begin m_run = 1; m_cyc = 0; m_cnt = 0; end
    end else if (sp) begin
      m_run = 0; m_tick = 0; m_done = 0;
    end else begin
      m_cyc++;
      pe = m_p < 2 ? 2 : m_p;
      ne = m_n == 0 ? 1 : m_n;
      m_tick = (m_cyc % pe) == 0;
      m_done = 0;
      if (m_tick) begin
        m_cnt++;
        if (m_cnt == ne) begin
          m_done = 1;
          if (m_mode) m_cnt = 0;
          else m_run = 0;
        end
      end
    end
  endtask

  task automatic cmp(input string name, input logic [10:0] got, input logic [10:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got tick=%0b done=%0b busy=%0b cnt=%0d want tick=%0b done=%0b busy=%0b cnt=%0d",
               name, got[10], got[9], got[8], got[7:0], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  function automatic logic [10:0] outs();
    return {tick, done, busy, tick_cnt};
  endfunction

  function automatic logic [10:0] mouts();
    return {m_tick, m_done, m_run, NTK_W'(m_cnt)};
  endfunction

  task automatic step(input string name, input bit r, we, input int p, n, input bit m, s, sp);
    rst = r; cfg_we = we; cfg_period = CNT_W'(p); cfg_ticks = NTK_W'(n); cfg_mode = m;
    start = s; stop = sp;
    @(posedge clk);
    model(r, we, p, n, m, s, sp);
    #1;
    cmp(name, outs(), mouts());
  endtask

  task automatic idle(input string name, input int k);
    for (int i = 0; i < k; i++) step(name, 0, 0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    bit r, we; int p, n; bit m, s, sp;
    logic [10:0] exp;
  } vec_t;
  vec_t vq[$];

  function automatic vec_t v(bit we, int p, int n, bit m, bit s, bit t, bit d, bit b, int c);
    vec_t x;
    x.r = 0; x.we = we; x.p = p; x.n = n; x.m = m; x.s = s; x.sp = 0;
    x.exp = {t, d, b, NTK_W'(c)};
    return x;
  endfunction

  initial begin
    // one-shot P=4 N=3
    vq.push_back(v(1, 4, 3, 0, 0, 0, 0, 0, 0));
    vq.push_back(v(0, 0, 0, 0, 1, 0, 0, 1, 0));
    for (int e = 1; e <= 13; e++)
      vq.push_back(v(0, 0, 0, 0, 0, e % 4 == 0 && e <= 12, e == 12, e < 12,
                     e < 4 ? 0 : e < 8 ? 1 : e < 12 ? 2 : 3));
    // P=1 N=0 behaves as P=2 N=1
    vq.push_back(v(1, 1, 0, 0, 0, 0, 0, 0, 3));
    vq.push_back(v(0, 0, 0, 0, 1, 0, 0, 1, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0));
    vq.push_back(v(0, 0, 0, 0, 0, 1, 1, 0, 1));
    vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1));
    // periodic P=3 N=2
    vq.push_back(v(1, 3, 2, 1, 0, 0, 0, 0, 1));
    vq.push_back(v(0, 0, 0, 0, 1, 0, 0, 1, 0));
    for (int e = 1; e <= 13; e++)
      vq.push_back(v(0, 0, 0, 0, 0, e % 3 == 0, e % 6 == 0, 1, (e / 3) % 2));

    // reset state
    step("rst0", 1, 0, 0, 0, 0, 0, 0);
    step("rst1", 1, 0, 0, 0, 0, 0, 0);
    cmp("reset_outs", outs(), 11'd0);
    foreach (vq[i]) begin
      step("vec_model", vq[i].r, vq[i].we, vq[i].p, vq[i].n, vq[i].m, vq[i].s, vq[i].sp);
      cmp($sformatf("vec%0d", i), outs(), vq[i].exp);
    end
    step("stop_periodic", 0, 0, 0, 0, 0, 0, 1);
    cmp("stop_periodic_busy", {10'd0, busy}, 11'd0);

    // default period: no tick long after start
    step("rst2", 1, 0, 0, 0, 0, 0, 0);
    step("start_default", 0, 0, 0, 0, 0, 1, 0);
    idle("default_run", 3000);
    cmp("default_busy", outs(), {3'b001, 8'd0});
    step("stop_default", 0, 0, 0, 0, 0, 0, 1);

    // stop coincident with second tick
    step("cfg_p4", 0, 1, 4, 3, 0, 0, 0);
    step("start_p4", 0, 0, 0, 0, 0, 1, 0);
    idle("p4_run", 7);
    step("stop_e8", 0, 0, 0, 0, 0, 0, 1);
    cmp("stop_e8_outs", outs(), {3'b000, 8'd1});
    idle("after_stop", 6);
    cmp("after_stop_hold", outs(), {3'b000, 8'd1});

    // cfg_we in RUN ignored
    step("cfg_p4n5", 0, 1, 4, 5, 1, 0, 0);
    step("start_p4n5", 0, 0, 0, 0, 0, 1, 0);
    idle("pre_cfg", 2);
    step("cfg_in_run", 0, 1, 10, 5, 0, 0, 0);
    step("e4", 0, 0, 0, 0, 0, 0, 0);
    cmp("e4_tick", outs(), {3'b101, 8'd1});
    idle("e5_7", 3);
    step("e8", 0, 0, 0, 0, 0, 0, 0);
    cmp("e8_tick", outs(), {3'b101, 8'd2});
    step("stop_cfg", 0, 0, 0, 0, 0, 0, 1);

    // reset mid-run restores default period
    step("start_p4b", 0, 0, 0, 0, 0, 1, 0);
    idle("p4b_run", 5);
    step("rst_e6", 1, 0, 0, 0, 0, 0, 0);
    cmp("rst_e6_outs", outs(), 11'd0);
    idle("post_rst", 3);
    cmp("no_tick_e8", outs(), 11'd0);
    step("start_after_rst", 0, 0, 0, 0, 0, 1, 0);
    idle("default_after_rst", 200);
    cmp("default_after_rst_outs", outs(), {3'b001, 8'd0});

    // randomized
    for (int i = 0; i < 6000; i++) begin
      bit r, we, m, s, sp;
      int p, n;
      r  = $urandom_range(0, 299) == 0;
      we = $urandom_range(0, 5) == 0;
      p  = $urandom_range(0, 7);
      n  = $urandom_range(0, 5);
      m  = $urandom_range(0, 1);
      s  = $urandom_range(0, 3) == 0;
      sp = $urandom_range(0, 39) == 0;
      step("random", r, we, p, n, m, s, sp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tick_ctrl.md
Name: tick_ctrl

Overview:
Programmable controller for the 20-bit prescale counter / terminal-count tick path. It holds the period and tick-count configuration and sequences start and stop. It emits a one-cycle tick every P clocks and a done pulse after N ticks, in one-shot or periodic mode. It sits between the register/switch front end and every consumer of the periodic tick.

Parameters:
CNT_W, 20, prescale counter width
NTK_W, 8, tick-count register width
DEFAULT_PERIOD, 1000000, period_r reset value (clocks per tick)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
cfg_we  in  1  config write strobe; honoured only in IDLE
cfg_period  in  CNT_W  period P in clocks
cfg_ticks  in  NTK_W  ticks per run N
cfg_mode  in  1  0 = one-shot, 1 = periodic
start  in  1  begin run; level, sampled each edge
stop  in  1  abort run; level, sampled each edge
tick  out  1  one-cycle pulse every P clocks while running
done  out  1  one-cycle pulse when N ticks are complete
busy  out  1  high in RUN
tick_cnt  out  NTK_W  ticks issued in the current run or period group

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high (rst); it applies in any state, including mid-run.
- Reset values:
  - state = IDLE; Q = 0; tick = 0; done = 0; busy = 0; tick_cnt = 0.
  - period_r = DEFAULT_PERIOD; ticks_r = 1; mode_r = 0.
- Effective values:
  - P_eff = max(period_r, 2).
  - N_eff = (ticks_r == 0) ? 1 : ticks_r.
- Config: in IDLE, cfg_we loads period_r, ticks_r and mode_r at the edge. In RUN, cfg_we is ignored.
- FSM has two states, IDLE and RUN.
  - IDLE -> RUN: start=1 and stop=0 at an edge (edge 0). At that edge Q <= 0, tick_cnt <= 0, busy <= 1.
  - RUN -> IDLE: stop=1, or one-shot completion.
  - start while in RUN is ignored.
  - start=1 and stop=1 together in IDLE: stay in IDLE.
- Counter Q, CNT_W bits, active in RUN only:
  - Q == P_eff-1 at an edge: Q <= 0, tick <= 1, tick_cnt <= tick_cnt+1.
  - Otherwise: Q <= Q+1, tick <= 0.
  - tick and done are registered. The first tick is high in the cycle after edge P_eff (counting edge 0 as the start edge). Later ticks follow every P_eff clocks. Ticks are never wider than one cycle.
- Completion: the tick edge at which tick_cnt+1 == N_eff.
  - One-shot: done <= 1, state <= IDLE, busy <= 0, tick_cnt holds N_eff. The final tick and done are high in the same cycle.
  - Periodic: done <= 1, tick_cnt <= 0, state stays RUN. The counter continues with no gap.
- stop in RUN: at that edge state <= IDLE, Q <= 0, tick <= 0, done <= 0, tick_cnt holds. stop beats a coincident tick or completion.
- Arithmetic: all comparisons are unsigned. Q never exceeds P_eff-1. tick_cnt never exceeds N_eff.
- rst mid-run: next cycle all outputs are at their reset values, and the config registers return to their defaults.

Decomposition:
- Package tick_pkg holds:
  - CNT_W, NTK_W, DEFAULT_PERIOD;
  - state encoding IDLE = 1'b0, RUN = 1'b1;
  - mode constants MODE_ONESHOT = 0, MODE_PERIODIC = 1.
- One sub-module, tick_prescaler, contains the counter plus terminal compare. Inputs: clk, rst, en, clr, period. Output: registered wrap pulse.
- tick_ctrl holds the config registers, the FSM, tick_cnt and done.

Test Plan:
1. Assert rst 2 cycles, then release -> tick = done = busy = 0, tick_cnt = 0; a start without config gives the first tick at edge 1000000.
2. cfg P=4, N=3, one-shot; start at edge 0 -> tick at edges 4, 8, 12; done only at edge 12; busy low after edge 12; tick_cnt = 3.
3. cfg P=3, N=2, periodic; start -> tick at edges 3, 6, 9, 12; done at edges 6 and 12; tick_cnt pattern 1, 0, 1, 0; busy stays high.
4. P=4, N=3; stop at edge 8, coincident with the second tick -> no tick at edge 8, no done, busy low; tick_cnt = 1 and holds.
5. cfg_we with P=10 during RUN (P=4) -> ignored, ticks stay 4 apart. cfg P=1, N=0 in IDLE -> behaves as P=2, N=1: one tick at edge 2, with done in the same cycle.
6. rst at edge 6 of a P=4 run -> all outputs 0 after that edge; period_r returns to 1000000; no tick at edge 8.
